// File: rtl/bus_arbiter_if.sv
// Shared-bus arbitration interface: requester side (req/lock/src/dst) and
// arbiter side (grant, mux select, destination enable, error, busy).
interface bus_arbiter_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]   req;
  logic [NREQ-1:0]   lock;
  logic [5*NREQ-1:0] src;
  logic [5*NREQ-1:0] dst;
  logic [NREQ-1:0]   gnt;
  logic [4:0]        mux_select;
  logic [31:0]       dst_en;
  logic [NREQ-1:0]   err;
  logic              busy;

  modport master (
    output req, lock, src, dst,
    input  gnt, mux_select, dst_en, err, busy
  );

  modport slave (
    input  req, lock, src, dst,
    output gnt, mux_select, dst_en, err, busy
  );
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin arbiter and transfer sequencer for the 32-bit internal bus.
// Optional lock timeout is built only when BUS_ARB_TIMEOUT_EN is defined.
//
// state | meaning
// IDLE  | no grant active, searching from ptr
// GRANT | first cycle of a grant to owner
// HOLD  | owner keeps the bus under lock
module bus_arbiter #(
  parameter int NREQ     = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic         clock,
  input  logic         clear,
  bus_arbiter_if.slave bus
);
  localparam int PW = $clog2(NREQ);

  typedef enum logic [1:0] {IDLE, GRANT, HOLD} state_t;

  state_t          state;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   owner;
  logic [NREQ-1:0] gnt_q;
  logic [NREQ-1:0] err_q;
  logic [4:0]      mux_q;
  logic [31:0]     dst_en_q;
  logic            busy_q;

  logic [4:0]      src_code [NREQ];
  logic [4:0]      dst_code [NREQ];
  logic [NREQ-1:0] code_ok;
  logic [NREQ-1:0] valid;
  logic [PW-1:0]   start;
  logic [PW-1:0]   idx;
  logic [PW-1:0]   win;
  logic            found;
  logic            timeout;
  logic            keep;

  function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] i);
    if (int'(i) == NREQ - 1) return '0;
    else return i + 1'b1;
  endfunction

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      src_code[i] = bus.src[5*i +: 5];
      dst_code[i] = bus.dst[5*i +: 5];
      code_ok[i]  = (src_code[i] <= 5'd23) && (dst_code[i] <= 5'd24);
    end
    valid = bus.req & code_ok;
  end

  // A grant that ends moves the search start just past its owner.
  assign start = (state == IDLE) ? ptr : next_idx(owner);

  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = PW'((int'(start) + k) % NREQ);
      if (!found && valid[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

`ifdef BUS_ARB_TIMEOUT_EN
  localparam int HW = $clog2(MAX_HOLD + 1);
  logic [HW-1:0] hold_cnt;

  assign timeout = (int'(hold_cnt) >= MAX_HOLD);

  always_ff @(posedge clock) begin
    if (clear) begin
      hold_cnt <= '0;
    end else if (keep) begin
      hold_cnt <= hold_cnt + 1'b1;
    end else if (found) begin
      hold_cnt <= HW'(1);
    end else begin
      hold_cnt <= '0;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  assign keep = (state != IDLE) && bus.req[owner] && bus.lock[owner] && !timeout;

  always_ff @(posedge clock) begin
    if (clear) begin
      state    <= IDLE;
      ptr      <= '0;
      owner    <= '0;
      gnt_q    <= '0;
      err_q    <= '0;
      mux_q    <= '0;
      dst_en_q <= '0;
      busy_q   <= 1'b0;
    end else begin
      err_q <= bus.req & ~code_ok;
      if (keep) begin
        state <= HOLD;
        // Invalid codes mid-hold suppress the load but keep the grant.
        if (code_ok[owner]) begin
          mux_q    <= src_code[owner];
          dst_en_q <= 32'd1 << dst_code[owner];
        end else begin
          dst_en_q <= '0;
        end
      end else begin
        if (state != IDLE) ptr <= next_idx(owner);
        if (found) begin
          state    <= GRANT;
          owner    <= win;
          gnt_q    <= {{(NREQ-1){1'b0}}, 1'b1} << win;
          mux_q    <= src_code[win];
          dst_en_q <= 32'd1 << dst_code[win];
          busy_q   <= 1'b1;
        end else begin
          state    <= IDLE;
          gnt_q    <= '0;
          dst_en_q <= '0;
          busy_q   <= 1'b0;
        end
      end
    end
  end

  assign bus.gnt        = gnt_q;
  assign bus.err        = err_q;
  assign bus.mux_select = mux_q;
  assign bus.dst_en     = dst_en_q;
  assign bus.busy       = busy_q;
endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed vector table, lock/clear
// sequences, then randomized traffic against a behavioural model.
module tb_bus_arbiter;
  localparam int NREQ     = 4;
  localparam int MAX_HOLD = 8;
`ifdef BUS_ARB_TIMEOUT_EN
  localparam bit TMO = 1'b1;
`else
  localparam bit TMO = 1'b0;
`endif

  logic clock;
  logic clear;
  int   n_cmp = 0;
  int   n_bad = 0;

  bus_arbiter_if #(.NREQ(NREQ)) bus ();

  bus_arbiter #(.NREQ(NREQ), .MAX_HOLD(MAX_HOLD)) dut (
    .clock(clock),
    .clear(clear),
    .bus  (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    logic        clr;
    logic [3:0]  req;
    logic [19:0] src;
    logic [19:0] dst;
    logic [3:0]  gnt;
    logic [4:0]  mux;
    logic [31:0] den;
    logic [3:0]  err;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [19:0] p4(input int a0, input int a1, input int a2, input int a3);
    return {a3[4:0], a2[4:0], a1[4:0], a0[4:0]};
  endfunction

  function automatic vec_t mk(input logic clr, input logic [3:0] req,
                              input logic [19:0] src, input logic [19:0] dst,
                              input logic [3:0] gnt, input logic [4:0] mux,
                              input logic [31:0] den, input logic [3:0] err);
    vec_t v;
    v.clr = clr; v.req = req; v.src = src; v.dst = dst;
    v.gnt = gnt; v.mux = mux; v.den = den; v.err = err;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [3:0] gnt, input logic [4:0] mux,
                         input logic [31:0] den, input logic [3:0] err);
    chk({tag, ".gnt"},  32'(bus.gnt), 32'(gnt));
    chk({tag, ".mux"},  32'(bus.mux_select), 32'(mux));
    chk({tag, ".den"},  bus.dst_en, den);
    chk({tag, ".err"},  32'(bus.err), 32'(err));
    chk({tag, ".busy"}, 32'(bus.busy), 32'(|gnt));
  endtask

  // Behavioural reference: owner index (-1 = none), search pointer, hold length.
  int          m_owner, m_ptr, m_held;
  logic [3:0]  m_gnt, m_err;
  logic [4:0]  m_mux;
  logic [31:0] m_den;

  task automatic model_step();
    logic [3:0] okv;
    int s, d, j;
    bit keep;
    for (int i = 0; i < NREQ; i++) begin
      s = int'(bus.src[5*i +: 5]);
      d = int'(bus.dst[5*i +: 5]);
      okv[i] = bus.req[i] && (s <= 23) && (d <= 24);
    end
    if (clear) begin
      m_owner = -1; m_ptr = 0; m_held = 0;
      m_gnt = '0; m_mux = '0; m_den = '0; m_err = '0;
      return;
    end
    m_err = bus.req & ~okv;
    keep = (m_owner >= 0) && bus.req[m_owner] && bus.lock[m_owner] &&
           (!TMO || m_held < MAX_HOLD);
    if (keep) begin
      m_held++;
      if (okv[m_owner]) begin
        m_mux = bus.src[5*m_owner +: 5];
        m_den = 32'd1 << int'(bus.dst[5*m_owner +: 5]);
      end else begin
        m_den = '0;
      end
    end else begin
      if (m_owner >= 0) m_ptr = (m_owner + 1) % NREQ;
      m_owner = -1;
      for (int k = 0; k < NREQ; k++) begin
        j = (m_ptr + k) % NREQ;
        if (m_owner < 0 && okv[j]) m_owner = j;
      end
      if (m_owner >= 0) begin
        m_held = 1;
        m_gnt  = 4'(1 << m_owner);
        m_mux  = bus.src[5*m_owner +: 5];
        m_den  = 32'd1 << int'(bus.dst[5*m_owner +: 5]);
      end else begin
        m_held = 0;
        m_gnt  = '0;
        m_den  = '0;
      end
    end
  endtask

  initial begin
    logic [19:0] bs, bd, rs, rd;
    int limit;

    clear = 1'b1;
    bus.req = '0; bus.lock = '0; bus.src = '0; bus.dst = '0;

    bs = p4(0, 16, 22, 23);
    bd = p4(18, 24, 0, 15);
    vecs.push_back(mk(1, 4'b0000, '0, '0, 4'b0000, 5'd0, 32'h0, 4'b0000));
    vecs.push_back(mk(0, 4'b0001, p4(20,0,0,0), p4(21,0,0,0), 4'b0001, 5'd20, 32'h0020_0000, 4'b0000));
    vecs.push_back(mk(0, 4'b0000, p4(20,0,0,0), p4(21,0,0,0), 4'b0000, 5'd20, 32'h0, 4'b0000));
    vecs.push_back(mk(1, 4'b0000, '0, '0, 4'b0000, 5'd0, 32'h0, 4'b0000));
    vecs.push_back(mk(0, 4'b1111, bs, bd, 4'b0001, 5'd0,  32'h0004_0000, 4'b0000));
    vecs.push_back(mk(0, 4'b1111, bs, bd, 4'b0010, 5'd16, 32'h0100_0000, 4'b0000));
    vecs.push_back(mk(0, 4'b1111, bs, bd, 4'b0100, 5'd22, 32'h0000_0001, 4'b0000));
    vecs.push_back(mk(0, 4'b1111, bs, bd, 4'b1000, 5'd23, 32'h0000_8000, 4'b0000));
    vecs.push_back(mk(0, 4'b1111, bs, bd, 4'b0001, 5'd0,  32'h0004_0000, 4'b0000));
    vecs.push_back(mk(0, 4'b0000, bs, bd, 4'b0000, 5'd0,  32'h0, 4'b0000));
    vecs.push_back(mk(0, 4'b0001, p4(27,0,0,0), p4(3,0,0,0), 4'b0000, 5'd0, 32'h0, 4'b0001));
    vecs.push_back(mk(0, 4'b0000, p4(27,0,0,0), p4(3,0,0,0), 4'b0000, 5'd0, 32'h0, 4'b0000));
    vecs.push_back(mk(0, 4'b0001, p4(23,0,0,0), p4(24,0,0,0), 4'b0001, 5'd23, 32'h0100_0000, 4'b0000));
    vecs.push_back(mk(0, 4'b0010, p4(0,24,0,0), p4(0,0,0,0), 4'b0000, 5'd23, 32'h0, 4'b0010));
    vecs.push_back(mk(0, 4'b0100, p4(0,0,5,0), p4(0,0,25,0), 4'b0000, 5'd23, 32'h0, 4'b0100));
    vecs.push_back(mk(0, 4'b0011, p4(31,17,0,0), p4(0,19,0,0), 4'b0010, 5'd17, 32'h0008_0000, 4'b0001));
    vecs.push_back(mk(0, 4'b0000, '0, '0, 4'b0000, 5'd17, 32'h0, 4'b0000));

    foreach (vecs[i]) begin
      clear   = vecs[i].clr;
      bus.req = vecs[i].req;
      bus.src = vecs[i].src;
      bus.dst = vecs[i].dst;
      tick();
      chk_all($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].mux, vecs[i].den, vecs[i].err);
    end

    // Locked requester 1 with requester 2 waiting.
    clear = 1'b1; bus.req = '0; tick(); clear = 1'b0;
    limit = TMO ? MAX_HOLD : 20;
    bus.req = 4'b0110; bus.lock = 4'b0010;
    for (int c = 0; c < limit; c++) begin
      bus.src = p4(0, c % 16, 21, 0);
      bus.dst = p4(0, (c == 3) ? 30 : 11, 20, 0);
      tick();
      chk($sformatf("hold%0d.gnt", c), 32'(bus.gnt), 32'h2);
      if (c == 3) begin
        chk("hold_bad.den", bus.dst_en, 32'h0);
        chk("hold_bad.err", 32'(bus.err), 32'h2);
      end else begin
        chk($sformatf("hold%0d.mux", c), 32'(bus.mux_select), 32'(c % 16));
        chk($sformatf("hold%0d.den", c), bus.dst_en, 32'h0000_0800);
        chk($sformatf("hold%0d.err", c), 32'(bus.err), 32'h0);
      end
    end
    bus.src = p4(0, 1, 21, 0);
    bus.dst = p4(0, 11, 20, 0);
    if (!TMO) begin
      bus.req = 4'b0100; bus.lock = '0;
    end
    tick();
    chk_all("hold_end", 4'b0100, 5'd21, 32'h0010_0000, 4'b0000);

    // Clear during HOLD resets outputs and the round-robin pointer.
    bus.req = '0; bus.lock = '0; tick();
    bus.req = 4'b0100; bus.lock = 4'b0100;
    bus.src = p4(4, 0, 7, 12); bus.dst = p4(5, 0, 9, 6);
    tick();
    chk_all("lk_grant", 4'b0100, 5'd7, 32'h0000_0200, 4'b0000);
    tick();
    chk_all("lk_hold", 4'b0100, 5'd7, 32'h0000_0200, 4'b0000);
    clear = 1'b1;
    tick();
    chk_all("clr_hold", 4'b0000, 5'd0, 32'h0, 4'b0000);
    clear = 1'b0; bus.req = 4'b1001; bus.lock = '0;
    tick();
    chk_all("clr_ptr", 4'b0001, 5'd4, 32'h0000_0020, 4'b0000);

    // Randomized traffic against the reference model.
    clear = 1'b1; bus.req = '0; bus.lock = '0;
    model_step();
    tick();
    chk_all("rnd_reset", m_gnt, m_mux, m_den, m_err);
    for (int c = 0; c < 600; c++) begin
      clear   = ($urandom_range(0, 99) == 0);
      bus.req = 4'($urandom);
      bus.lock = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
      for (int i = 0; i < NREQ; i++) begin
        rs[5*i +: 5] = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(24, 31)) : 5'($urandom_range(0, 23));
        rd[5*i +: 5] = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(25, 31)) : 5'($urandom_range(0, 24));
      end
      bus.src = rs;
      bus.dst = rd;
      model_step();
      tick();
      chk_all($sformatf("rnd%0d", c), m_gnt, m_mux, m_den, m_err);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
